// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the clock-divider monitor.
// Optional error counter is built only when CLK_MON_ERR_CNT_EN is defined.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        MEASURE,
        LOCKED
    } state_t;

    localparam int HC_W   = 8;
    localparam int HC_MAX = 255;

endpackage

// File: rtl/clk_div_monitor_if.sv
// Monitor control/result bundle; master drives enable and the clock under test,
// slave (the monitor) returns measurements and status.
interface clk_div_monitor_if;
    import clk_mon_pkg::*;

    logic            en;
    logic            mon_in;
    logic [HC_W-1:0] period_hc;
    logic [HC_W-1:0] high_hc;
    logic            meas_valid;
    logic            lock;
    logic            err;
    logic [HC_W-1:0] err_cnt;

    modport master (
        output en, mon_in,
        input  period_hc, high_hc, meas_valid, lock, err, err_cnt
    );

    modport slave (
        input  en, mon_in,
        output period_hc, high_hc, meas_valid, lock, err, err_cnt
    );

endinterface

// File: rtl/clk_mon_dual_edge_sampler.sv
// Samples the monitored clock on both reference edges and presents each
// negedge/posedge half-sample pair, plus the half-sample that preceded it.
module clk_mon_dual_edge_sampler (
    input  logic clk_in,
    input  logic reset,
    input  logic mon_in,
    output logic h0,
    output logic h1,
    output logic last
);

    logic neg_s;

    // NOTE: non-blocking assignments so every flop captures pre-edge values.
    always_ff @(negedge clk_in or posedge reset) begin
        if (reset) neg_s <= 1'b0;
        else       neg_s <= mon_in;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            h0   <= 1'b0;
            h1   <= 1'b0;
            last <= 1'b0;
        end else begin
            h0   <= neg_s;
            h1   <= mon_in;
            last <= h1;
        end
    end

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock in reference half-cycles and
// tracks lock against EXP_DIV. err_cnt is built only with CLK_MON_ERR_CNT_EN.
module clk_div_monitor
    import clk_mon_pkg::*;
#(
    parameter int EXP_DIV  = 3,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    clk_div_monitor_if.slave bus
);

    localparam int              WIN_W       = HC_W + 1;
    localparam logic [HC_W-1:0] GOOD_PERIOD = HC_W'(2 * EXP_DIV);
    localparam logic [HC_W-1:0] GOOD_HIGH   = HC_W'(EXP_DIV);
    localparam logic [3:0]      LOCK_TGT    = 4'(LOCK_CNT);

    logic h0, h1, last;

    state_t          state, state_nxt;
    logic [3:0]      good_cnt, good_cnt_nxt;
    logic [HC_W-1:0] win_cnt, win_cnt_nxt;
    logic [HC_W-1:0] win_high, win_high_nxt;
    logic [HC_W-1:0] period_q, period_nxt;
    logic [HC_W-1:0] high_q, high_nxt;
    logic            meas_q, meas_nxt;
    logic            err_q, err_nxt;

    logic             rise_lo, rise_hi, rise, good, timeout;
    logic [HC_W-1:0]  cls_period, open_cnt, open_high, run_high;
    logic [WIN_W-1:0] run_cnt;

    clk_mon_dual_edge_sampler u_sampler (
        .clk_in (clk_in),
        .reset  (reset),
        .mon_in (bus.mon_in),
        .h0     (h0),
        .h1     (h1),
        .last   (last)
    );

    // A rising half-sample either leads the pair (h0) or trails it (h1).
    // In the h1 case the closing window also owns h0, which is 0 by definition.
    assign rise_lo    = h0 & ~last;
    assign rise_hi    = h1 & ~h0;
    assign rise       = rise_lo | rise_hi;
    assign cls_period = rise_lo ? win_cnt : win_cnt + HC_W'(1);
    assign good       = (cls_period == GOOD_PERIOD) && (win_high == GOOD_HIGH);
    assign open_cnt   = rise_lo ? HC_W'(2) : HC_W'(1);
    assign open_high  = (rise_lo && h1) ? HC_W'(2) : HC_W'(1);
    assign run_cnt    = {1'b0, win_cnt} + WIN_W'(2);
    assign run_high   = win_high + HC_W'(h0) + HC_W'(h1);
    assign timeout    = !rise && (run_cnt >= WIN_W'(HC_MAX));

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        win_cnt_nxt  = win_cnt;
        win_high_nxt = win_high;
        period_nxt   = period_q;
        high_nxt     = high_q;
        meas_nxt     = 1'b0;
        err_nxt      = 1'b0;

        if (!bus.en) begin
            state_nxt    = IDLE;
            good_cnt_nxt = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt    = ACQUIRE;
                    good_cnt_nxt = '0;
                end
                ACQUIRE: begin
                    if (rise) begin
                        state_nxt    = MEASURE;
                        good_cnt_nxt = '0;
                        win_cnt_nxt  = open_cnt;
                        win_high_nxt = open_high;
                    end
                end
                MEASURE, LOCKED: begin
                    if (rise) begin
                        meas_nxt     = 1'b1;
                        period_nxt   = cls_period;
                        high_nxt     = win_high;
                        win_cnt_nxt  = open_cnt;
                        win_high_nxt = open_high;
                        if (!good) begin
                            err_nxt      = 1'b1;
                            good_cnt_nxt = '0;
                            state_nxt    = MEASURE;
                        end else if (state == MEASURE) begin
                            if (good_cnt + 4'd1 == LOCK_TGT) begin
                                state_nxt    = LOCKED;
                                good_cnt_nxt = '0;
                            end else begin
                                good_cnt_nxt = good_cnt + 4'd1;
                            end
                        end
                    end else if (timeout) begin
                        // Window abandoned; last reported measurement stays.
                        err_nxt      = 1'b1;
                        good_cnt_nxt = '0;
                        state_nxt    = ACQUIRE;
                    end else begin
                        win_cnt_nxt  = run_cnt[HC_W-1:0];
                        win_high_nxt = run_high;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            good_cnt <= '0;
            win_cnt  <= '0;
            win_high <= '0;
            period_q <= '0;
            high_q   <= '0;
            meas_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            good_cnt <= good_cnt_nxt;
            win_cnt  <= win_cnt_nxt;
            win_high <= win_high_nxt;
            period_q <= period_nxt;
            high_q   <= high_nxt;
            meas_q   <= meas_nxt;
            err_q    <= err_nxt;
        end
    end

`ifdef CLK_MON_ERR_CNT_EN
    logic [HC_W-1:0] err_cnt_q;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)                                      err_cnt_q <= '0;
        else if (err_nxt && err_cnt_q != HC_W'(HC_MAX)) err_cnt_q <= err_cnt_q + HC_W'(1);
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = '0;
`endif

    assign bus.period_hc  = period_q;
    assign bus.high_hc    = high_q;
    assign bus.meas_valid = meas_q;
    assign bus.err        = err_q;
    assign bus.lock       = (state == LOCKED);

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: a table of waveform segments with expected
// pulse counts and results, followed by reset, timeout, enable and saturation cases.
module tb_clk_div_monitor;
    import clk_mon_pkg::*;

`ifdef CLK_MON_ERR_CNT_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    typedef struct {
        int hi;       // high half-cycles per period
        int lo;       // low half-cycles per period
        int reps;     // periods driven (each starts with a rising edge)
        int d_meas;   // expected meas_valid pulses during the segment
        int d_err;    // expected err pulses during the segment
        int period;   // expected period_hc afterwards
        int high;     // expected high_hc afterwards
        int lock;     // expected lock afterwards
    } vec_t;

    logic clk_in = 1'b0;
    logic reset;

    clk_div_monitor_if bus ();

    clk_div_monitor #(
        .EXP_DIV  (3),
        .LOCK_CNT (4)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_pass = 0;
    int meas_seen = 0;
    int err_seen  = 0;
    int cyc = 0;
    int last_cyc = 0;
    int gap = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (bus.meas_valid) begin
            meas_seen <= meas_seen + 1;
            gap       <= cyc - last_cyc;
            last_cyc  <= cyc;
        end
        if (bus.err) err_seen <= err_seen + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Drive one half-sample; it is captured on the next reference edge.
    task automatic half(input logic v);
        bus.mon_in = v;
        @(posedge clk_in or negedge clk_in);
        #1;
    endtask

    task automatic wave(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi; i++) half(1'b1);
            for (int i = 0; i < lo; i++) half(1'b0);
        end
    endtask

    task automatic zeros(input int n);
        for (int i = 0; i < n; i++) half(1'b0);
    endtask

    vec_t vecs[13];
    int   m0, e0, n;

    initial begin
        vecs[0]  = '{3, 3, 1, 0, 0, 0, 0, 0};
        vecs[1]  = '{3, 3, 3, 3, 0, 6, 3, 0};
        vecs[2]  = '{3, 3, 1, 1, 0, 6, 3, 1};
        vecs[3]  = '{4, 2, 1, 1, 0, 6, 3, 1};
        vecs[4]  = '{3, 3, 1, 1, 1, 6, 4, 0};
        vecs[5]  = '{3, 3, 3, 3, 0, 6, 3, 0};
        vecs[6]  = '{3, 3, 1, 1, 0, 6, 3, 1};
        vecs[7]  = '{4, 4, 2, 2, 1, 8, 4, 0};
        vecs[8]  = '{3, 3, 1, 1, 1, 8, 4, 0};
        vecs[9]  = '{3, 3, 4, 4, 0, 6, 3, 1};
        vecs[10] = '{3, 4, 1, 1, 0, 6, 3, 1};
        vecs[11] = '{3, 3, 4, 4, 1, 6, 3, 0};
        vecs[12] = '{3, 3, 1, 1, 0, 6, 3, 1};

        reset      = 1'b1;
        bus.en     = 1'b0;
        bus.mon_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_period",  int'(bus.period_hc),  0);
        check("rst_high",    int'(bus.high_hc),    0);
        check("rst_meas",    int'(bus.meas_valid), 0);
        check("rst_lock",    int'(bus.lock),       0);
        check("rst_err",     int'(bus.err),        0);
        check("rst_err_cnt", int'(bus.err_cnt),    0);

        reset  = 1'b0;
        bus.en = 1'b1;
        zeros(4);

        for (int i = 0; i < 13; i++) begin
            m0 = meas_seen;
            e0 = err_seen;
            wave(vecs[i].hi, vecs[i].lo, vecs[i].reps);
            check($sformatf("vec%0d_meas", i),   meas_seen - m0,         vecs[i].d_meas);
            check($sformatf("vec%0d_err", i),    err_seen - e0,          vecs[i].d_err);
            check($sformatf("vec%0d_period", i), int'(bus.period_hc),    vecs[i].period);
            check($sformatf("vec%0d_high", i),   int'(bus.high_hc),      vecs[i].high);
            check($sformatf("vec%0d_lock", i),   int'(bus.lock),         vecs[i].lock);
        end
        check("meas_gap_cycles", gap, 3);

        // Reset in the middle of a window while locked.
        half(1'b1);
        half(1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_period",  int'(bus.period_hc),  0);
        check("midrst_high",    int'(bus.high_hc),    0);
        check("midrst_meas",    int'(bus.meas_valid), 0);
        check("midrst_lock",    int'(bus.lock),       0);
        check("midrst_err",     int'(bus.err),        0);
        check("midrst_err_cnt", int'(bus.err_cnt),    0);
        bus.mon_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        reset = 1'b0;
        m0 = meas_seen;
        zeros(4);
        wave(3, 3, 1);
        check("postrst_first_edge_no_meas", meas_seen - m0, 0);
        wave(3, 3, 1);
        check("postrst_second_edge_meas", meas_seen - m0, 1);
        check("postrst_period", int'(bus.period_hc), 6);
        wave(3, 3, 3);
        check("postrst_lock", int'(bus.lock), 1);

        // Monitored clock stuck low while locked.
        m0 = meas_seen;
        e0 = err_seen;
        n  = 0;
        while (err_seen == e0 && n < 300) begin
            half(1'b0);
            n++;
        end
        check("timeout_err_pulses", err_seen - e0, 1);
        check("timeout_near_255", int'((6 + n >= 255) && (6 + n <= 262)), 1);
        check("timeout_state",   int'(dut.state),      int'(ACQUIRE));
        check("timeout_lock",    int'(bus.lock),       0);
        check("timeout_err_cnt", int'(bus.err_cnt),    ERR_EN);
        check("timeout_period",  int'(bus.period_hc),  6);
        check("timeout_high",    int'(bus.high_hc),    3);
        check("timeout_no_meas", meas_seen - m0,       0);

        e0 = err_seen;
        wave(3, 3, 5);
        check("relock_lock", int'(bus.lock), 1);
        check("relock_err",  err_seen - e0,  0);

        // Enable dropped for 10 reference cycles while locked.
        m0 = meas_seen;
        e0 = err_seen;
        bus.en = 1'b0;
        wave(3, 3, 3);
        zeros(2);
        check("endrop_lock",   int'(bus.lock),      0);
        check("endrop_meas",   meas_seen - m0,      0);
        check("endrop_err",    err_seen - e0,       0);
        check("endrop_period", int'(bus.period_hc), 6);
        check("endrop_high",   int'(bus.high_hc),   3);
        bus.en = 1'b1;
        m0 = meas_seen;
        zeros(4);
        wave(3, 3, 4);
        check("reen_three_good_no_lock", int'(bus.lock), 0);
        check("reen_meas", meas_seen - m0, 3);
        wave(3, 3, 1);
        check("reen_fourth_good_lock", int'(bus.lock), 1);

        // Long run of short periods: every closed window is a mismatch.
        m0 = meas_seen;
        e0 = err_seen;
        wave(2, 2, 601);
        zeros(8);
        check("sat_meas",    meas_seen - m0,     601);
        check("sat_err",     err_seen - e0,      600);
        check("sat_period",  int'(bus.period_hc), 4);
        check("sat_high",    int'(bus.high_hc),   2);
        check("sat_lock",    int'(bus.lock),      0);
        check("sat_err_cnt", int'(bus.err_cnt),   ERR_EN * 255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
